// File: rtl/game_display_driver.sv
// VGA raster generator and pin driver for the game core: produces the pixel
// strobe, counter-derived x/y/display_on, and colour/sync outputs kept aligned.
module game_display_driver #(
    parameter int clk_mhz       = 50,
    parameter int pixel_mhz     = 25,
    parameter int screen_width  = 640,
    parameter int screen_height = 480,
    parameter int h_front       = 16,
    parameter int h_sync        = 96,
    parameter int h_back        = 48,
    parameter int v_front       = 10,
    parameter int v_sync        = 2,
    parameter int v_back        = 33,
    parameter int rgb_width     = 3,
    parameter int rgb_latency   = 1,
    parameter int w_x           = $clog2(screen_width),
    parameter int w_y           = $clog2(screen_height)
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 display_on,
    output logic [w_x-1:0]       x,
    output logic [w_y-1:0]       y,
    output logic                 pixel_en,
    output logic                 frame_start,
    input  logic [rgb_width-1:0] rgb,
    output logic                 vga_hsync,
    output logic                 vga_vsync,
    output logic [rgb_width-1:0] vga_rgb
);

    localparam int CLK_DIV = clk_mhz / pixel_mhz;
    localparam int H_TOTAL = screen_width + h_front + h_sync + h_back;
    localparam int V_TOTAL = screen_height + v_front + v_sync + v_back;
    localparam int W_DIV   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int W_H     = $clog2(H_TOTAL);
    localparam int W_V     = $clog2(V_TOTAL);

    localparam logic [W_DIV-1:0] DIV_LAST = W_DIV'(CLK_DIV - 1);
    localparam logic [W_H-1:0]   H_LAST   = W_H'(H_TOTAL - 1);
    localparam logic [W_V-1:0]   V_LAST   = W_V'(V_TOTAL - 1);
    localparam logic [W_H-1:0]   H_VIS    = W_H'(screen_width);
    localparam logic [W_V-1:0]   V_VIS    = W_V'(screen_height);
    localparam logic [W_H-1:0]   HS_BEG   = W_H'(screen_width + h_front);
    localparam logic [W_H-1:0]   HS_END   = W_H'(screen_width + h_front + h_sync);
    localparam logic [W_V-1:0]   VS_BEG   = W_V'(screen_height + v_front);
    localparam logic [W_V-1:0]   VS_END   = W_V'(screen_height + v_front + v_sync);

    // Stage layout: {display_on, hs_raw, vs_raw}; reset value is blank with syncs idle.
    localparam logic [2:0] STAGE_IDLE = 3'b011;

    logic [W_DIV-1:0] div_r;
    logic [W_H-1:0]   h_cnt_r;
    logic [W_V-1:0]   v_cnt_r;
    logic             h_wrap_s;
    logic             frame_wrap_s;
    logic             hs_raw_s;
    logic             vs_raw_s;
    logic [2:0]       raw_s;
    logic [2:0]       dly_s;

    assign pixel_en     = (div_r == DIV_LAST);
    assign h_wrap_s     = (h_cnt_r == H_LAST);
    assign frame_wrap_s = pixel_en && h_wrap_s && (v_cnt_r == V_LAST);

    // Clock divider producing the one-clk pixel strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r <= {W_DIV{1'b0}};
        end else if (div_r == DIV_LAST) begin
            div_r <= {W_DIV{1'b0}};
        end else begin
            div_r <= div_r + W_DIV'(1);
        end
    end

    // Raster position counters, advanced only on the pixel strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_r <= {W_H{1'b0}};
            v_cnt_r <= {W_V{1'b0}};
        end else if (pixel_en) begin
            if (h_wrap_s) begin
                h_cnt_r <= {W_H{1'b0}};
                if (v_cnt_r == V_LAST) begin
                    v_cnt_r <= {W_V{1'b0}};
                end else begin
                    v_cnt_r <= v_cnt_r + W_V'(1);
                end
            end else begin
                h_cnt_r <= h_cnt_r + W_H'(1);
            end
        end
    end

    // Position decode presented to the game core.
    always_comb begin
        display_on = (h_cnt_r < H_VIS) && (v_cnt_r < V_VIS);
        if (display_on) begin
            x = h_cnt_r[w_x-1:0];
            y = v_cnt_r[w_y-1:0];
        end else begin
            x = {w_x{1'b0}};
            y = {w_y{1'b0}};
        end
        hs_raw_s = !((h_cnt_r >= HS_BEG) && (h_cnt_r < HS_END));
        vs_raw_s = !((v_cnt_r >= VS_BEG) && (v_cnt_r < VS_END));
        raw_s    = {display_on, hs_raw_s, vs_raw_s};
    end

    // Match the game core's colour latency so syncs and blanking line up with rgb.
    generate
        if (rgb_latency == 0) begin : g_bypass
            assign dly_s = raw_s;
        end else begin : g_pipe
            logic [2:0] pipe_r [rgb_latency];

            // Shift register of decoded timing, one stage per pixel strobe.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < rgb_latency; i++) begin
                        pipe_r[i] <= STAGE_IDLE;
                    end
                end else if (pixel_en) begin
                    pipe_r[0] <= raw_s;
                    for (int i = 1; i < rgb_latency; i++) begin
                        pipe_r[i] <= pipe_r[i-1];
                    end
                end
            end

            assign dly_s = pipe_r[rgb_latency-1];
        end
    endgenerate

    // Pin registers; colour is only trusted while the aligned display_on is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_hsync <= 1'b1;
            vga_vsync <= 1'b1;
            vga_rgb   <= {rgb_width{1'b0}};
        end else if (pixel_en) begin
            vga_hsync <= dly_s[1];
            vga_vsync <= dly_s[0];
            vga_rgb   <= dly_s[2] ? rgb : {rgb_width{1'b0}};
        end
    end

    // Frame pulse follows the strobe that wraps the raster back to the origin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_wrap_s;
        end
    end

endmodule

// File: tb/tb_game_display_driver.sv
// Scoreboard bench for game_display_driver on a reduced raster, with three
// instances at colour latencies 0, 1 and 3 sharing clock and reset.
module tb_game_display_driver;

    localparam int W   = 16;
    localparam int HF  = 2;
    localparam int HSW = 3;
    localparam int HBK = 3;
    localparam int HT  = W + HF + HSW + HBK;
    localparam int H   = 6;
    localparam int VF  = 1;
    localparam int VSW = 2;
    localparam int VBK = 1;
    localparam int VT  = H + VF + VSW + VBK;
    localparam int DIV = 2;
    localparam int FRAME_CLKS = HT * VT * DIV;
    localparam int HS0 = W + HF;
    localparam int HS1 = W + HF + HSW;
    localparam int VS0 = H + VF;
    localparam int VS1 = H + VF + VSW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mode = 1'b0;

    int total = 0;
    int bad = 0;
    int lat_tab [3] = '{0, 1, 3};

    int mdiv = 0, mh = 0, mv = 0, gcyc = 0;
    bit fs_exp = 1'b0;
    int n_hs_low, n_vs_low, n_vis, n_lines, n_white;

    logic [4:0] q0 [$];
    logic [4:0] q1 [$];
    logic [4:0] q3 [$];

    logic       don0, don1, don3, pen0, pen1, pen3, fs0, fs1, fs3;
    logic       hs0, hs1, hs3, vs0, vs1, vs3;
    logic [3:0] x0, x1, x3;
    logic [2:0] y0, y1, y3;
    logic [2:0] rgb0, rgb1, rgb3, vrgb0, vrgb1, vrgb3;
    logic [3:0] core_pipe [3];
    logic [9:0] tim [3];
    logic [4:0] pin [3];

    always #5 clk = ~clk;

    game_display_driver #(.clk_mhz(50), .pixel_mhz(25), .screen_width(W), .screen_height(H),
        .h_front(HF), .h_sync(HSW), .h_back(HBK), .v_front(VF), .v_sync(VSW), .v_back(VBK),
        .rgb_width(3), .rgb_latency(0)) u_lat0 (
        .clk(clk), .rst(rst), .display_on(don0), .x(x0), .y(y0), .pixel_en(pen0),
        .frame_start(fs0), .rgb(rgb0), .vga_hsync(hs0), .vga_vsync(vs0), .vga_rgb(vrgb0));

    game_display_driver #(.clk_mhz(50), .pixel_mhz(25), .screen_width(W), .screen_height(H),
        .h_front(HF), .h_sync(HSW), .h_back(HBK), .v_front(VF), .v_sync(VSW), .v_back(VBK),
        .rgb_width(3), .rgb_latency(1)) u_lat1 (
        .clk(clk), .rst(rst), .display_on(don1), .x(x1), .y(y1), .pixel_en(pen1),
        .frame_start(fs1), .rgb(rgb1), .vga_hsync(hs1), .vga_vsync(vs1), .vga_rgb(vrgb1));

    game_display_driver #(.clk_mhz(50), .pixel_mhz(25), .screen_width(W), .screen_height(H),
        .h_front(HF), .h_sync(HSW), .h_back(HBK), .v_front(VF), .v_sync(VSW), .v_back(VBK),
        .rgb_width(3), .rgb_latency(3)) u_lat3 (
        .clk(clk), .rst(rst), .display_on(don3), .x(x3), .y(y3), .pixel_en(pen3),
        .frame_start(fs3), .rgb(rgb3), .vga_hsync(hs3), .vga_vsync(vs3), .vga_rgb(vrgb3));

    assign tim[0] = {don0, x0, y0, pen0, fs0};
    assign tim[1] = {don1, x1, y1, pen1, fs1};
    assign tim[2] = {don3, x3, y3, pen3, fs3};
    assign pin[0] = {hs0, vs0, vrgb0};
    assign pin[1] = {hs1, vs1, vrgb1};
    assign pin[2] = {hs3, vs3, vrgb3};

    // Emulated game core: colour is column mod 8 (or all-ones in mode 1), returned after its latency.
    always @(posedge clk) begin
        if (pen1 === 1'b1) begin
            core_pipe[0] <= {mode, x1[2:0]};
            core_pipe[1] <= core_pipe[0];
            core_pipe[2] <= core_pipe[1];
        end
    end

    assign rgb0 = mode ? 3'b111 : x0[2:0];
    assign rgb1 = core_pipe[0][3] ? 3'b111 : core_pipe[0][2:0];
    assign rgb3 = core_pipe[2][3] ? 3'b111 : core_pipe[2][2:0];

    task automatic sb_push(input int k, input logic [4:0] e);
        case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    function automatic logic [4:0] sb_pop(input int k);
        case (k)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q3.pop_front();
        endcase
    endfunction

    task automatic model_reset();
        mdiv = 0; mh = 0; mv = 0; fs_exp = 1'b0;
        q0.delete(); q1.delete(); q3.delete();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < lat_tab[k]; i++) sb_push(k, 5'b11000);
    endtask

    task automatic clear_stats();
        n_hs_low = 0; n_vs_low = 0; n_vis = 0; n_lines = 0; n_white = 0;
    endtask

    // One clock: check timing outputs, push/pop scoreboard on strobes, advance the model.
    task automatic tick();
        logic [4:0] ex [3];
        logic [9:0] et;
        logic [2:0] col;
        bit strobe, vis, wrap, hs_e, vs_e;
        strobe = (mdiv == DIV - 1);
        vis = (mh < W) && (mv < H);
        et = {vis, vis ? 4'(mh) : 4'd0, vis ? 3'(mv) : 3'd0, strobe, fs_exp};
        for (int k = 0; k < 3; k++) begin
            total++;
            if (tim[k] !== et) begin
                bad++;
                $display("FAIL timing lat%0d at (%0d,%0d): got %b want %b", lat_tab[k], mh, mv, tim[k], et);
            end
        end
        if (strobe) begin
            col  = 3'(mh);
            hs_e = !(mh >= HS0 && mh < HS1);
            vs_e = !(mv >= VS0 && mv < VS1);
            for (int k = 0; k < 3; k++) begin
                sb_push(k, {hs_e, vs_e, vis ? (mode ? 3'b111 : col) : 3'b000});
                ex[k] = sb_pop(k);
            end
            if (don1 === 1'b1) n_vis++;
            if (don1 === 1'b1 && x1 === 4'd0) n_lines++;
        end
        wrap = strobe && (mh == HT - 1) && (mv == VT - 1);
        @(posedge clk);
        #1;
        if (strobe) begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (pin[k] !== ex[k]) begin
                    bad++;
                    $display("FAIL pins lat%0d near (%0d,%0d): got {hs,vs,rgb}=%b want %b", lat_tab[k], mh, mv, pin[k], ex[k]);
                end
            end
            if (hs1 === 1'b0) n_hs_low++;
            if (vs1 === 1'b0) n_vs_low++;
            if (vrgb1 === 3'b111) n_white++;
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
        end
        fs_exp = wrap;
        mdiv = (mdiv + 1) % DIV;
        gcyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int n;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (pin[k] !== 5'b11000) begin
                bad++; $display("FAIL reset_pins lat%0d: got %b want 11000", lat_tab[k], pin[k]);
            end
            total++;
            if (tim[k] !== 10'b1_0000_000_0_0) begin
                bad++; $display("FAIL reset_timing lat%0d: got %b want 1000000000", lat_tab[k], tim[k]);
            end
        end
        rst = 1'b0;
        model_reset();
        n = 0;
        while (x1 !== 4'd1 && n < 8) begin
            tick();
            n++;
        end
        total++;
        if (n != 2) begin
            bad++; $display("FAIL first_strobe: x reached 1 after %0d clks, want 2", n);
        end
    endtask

    task automatic test_column_pattern();
        mode = 1'b0;
        for (int i = 0; i < 2 * FRAME_CLKS; i++) tick();
    endtask

    task automatic test_sync_counts();
        mode = 1'b0;
        clear_stats();
        for (int i = 0; i < FRAME_CLKS; i++) tick();
        total++;
        if (n_hs_low != HSW * VT) begin
            bad++; $display("FAIL hsync_low: got %0d strobes want %0d", n_hs_low, HSW * VT);
        end
        total++;
        if (n_vs_low != VSW * HT) begin
            bad++; $display("FAIL vsync_low: got %0d strobes want %0d", n_vs_low, VSW * HT);
        end
        total++;
        if (n_vis != W * H) begin
            bad++; $display("FAIL visible_pixels: got %0d want %0d", n_vis, W * H);
        end
        total++;
        if (n_lines != H) begin
            bad++; $display("FAIL visible_lines: got %0d want %0d", n_lines, H);
        end
    endtask

    task automatic test_blank_force();
        mode = 1'b1;
        for (int i = 0; i < FRAME_CLKS + 10; i++) tick();
        clear_stats();
        for (int i = 0; i < FRAME_CLKS; i++) tick();
        total++;
        if (n_white != W * H) begin
            bad++; $display("FAIL blank_force: got %0d white strobes want %0d", n_white, W * H);
        end
    endtask

    task automatic test_frame_interval();
        int t0 = -1;
        int t1 = -1;
        for (int i = 0; i < 3 * FRAME_CLKS && t1 < 0; i++) begin
            tick();
            if (fs1 === 1'b1) begin
                if (t0 < 0) t0 = gcyc;
                else t1 = gcyc;
            end
        end
        total++;
        if (t1 < 0 || (t1 - t0) != FRAME_CLKS) begin
            bad++; $display("FAIL frame_interval: got %0d clks want %0d", t1 - t0, FRAME_CLKS);
        end
    endtask

    task automatic test_midframe_reset();
        int n;
        mode = 1'b1;
        for (int i = 0; i < 2 * FRAME_CLKS && !(mh == 10 && mv == 3 && mdiv == 0); i++) tick();
        total++;
        if (vrgb1 !== 3'b111) begin
            bad++; $display("FAIL pre_reset_rgb: got %b want 111", vrgb1);
        end
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (pin[k] !== 5'b11000) begin
                bad++; $display("FAIL async_reset_pins lat%0d: got %b want 11000", lat_tab[k], pin[k]);
            end
            total++;
            if (tim[k] !== 10'b1_0000_000_0_0) begin
                bad++; $display("FAIL async_reset_timing lat%0d: got %b want 1000000000", lat_tab[k], tim[k]);
            end
        end
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;
        model_reset();
        n = 0;
        while (fs1 !== 1'b1 && n < 2 * FRAME_CLKS) begin
            tick();
            n++;
        end
        total++;
        if (n != FRAME_CLKS) begin
            bad++; $display("FAIL restart_frame_start: after %0d clks want %0d", n, FRAME_CLKS);
        end
    endtask

    initial begin
        test_reset();
        test_column_pattern();
        test_sync_counts();
        test_blank_force();
        test_frame_interval();
        test_midframe_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
